// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and helpers: complex sample packing and constant log2.
package fft_pkg;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_HALF_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Real part sits in the upper half of a packed complex sample, imaginary in the lower.
  function automatic logic [FFT_HALF_W-1:0] re(input logic [FFT_DATA_W-1:0] x);
    return x[FFT_DATA_W-1:FFT_HALF_W];
  endfunction

  function automatic logic [FFT_HALF_W-1:0] im(input logic [FFT_DATA_W-1:0] x);
    return x[FFT_HALF_W-1:0];
  endfunction
endpackage

// File: rtl/fft_delay_ram.sv
// Half-block delay memory: one synchronous write port, one asynchronous read port, no reset.
module fft_delay_ram #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fft_pair_commutator.sv
// Radix-2 pairing stage: buffers x[0..DEPTH-1] of each block, then emits (x[k], x[k+DEPTH]).
module fft_pair_commutator
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int DEPTH  = 8,
  parameter int TW_W   = 1
) (
  input  logic              clock_c,
  input  logic              reset_n,
  input  logic              sync_clr,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_en,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TW_W-1:0]   out_tw,
  output logic              out_first
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     r_cnt;
  logic              w_pair;
  logic [AW-1:0]     w_k;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_pair  = r_cnt[AW];
  assign w_k     = r_cnt[AW-1:0];
  // A restart always lands its sample at slot 0, whatever phase the counter was in.
  assign w_we    = in_en && (sync_clr || !w_pair);
  assign w_waddr = sync_clr ? '0 : w_k;

  fft_delay_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
    .i_clk   (clock_c),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_raddr (w_k),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      out_en    <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_tw    <= '0;
      out_first <= 1'b0;
    end else if (sync_clr) begin
      r_cnt     <= {{AW{1'b0}}, in_en};
      out_en    <= 1'b0;
      out_first <= 1'b0;
    end else if (in_en) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_pair) begin
        out_a     <= w_rdata;
        out_b     <= in_data;
        out_tw    <= w_k[AW-1 -: TW_W];
        out_en    <= 1'b1;
        out_first <= (w_k == '0);
      end else begin
        out_en    <= 1'b0;
        out_first <= 1'b0;
      end
    end else begin
      out_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_pair_commutator.sv
// Directed checks of the pairing stage at DEPTH=4 plus a DEPTH=512 scoreboard run.
module tb_fft_pair_commutator;
  logic        clock_c = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_clr = 1'b0, in_en = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_en, out_first;
  logic [15:0] out_a, out_b;
  logic [0:0]  out_tw;

  logic        sync_clr2 = 1'b0, in_en2 = 1'b0;
  logic [15:0] in_data2 = '0;
  logic        out_en2, out_first2;
  logic [15:0] out_a2, out_b2;
  logic [0:0]  out_tw2;

  int total = 0;
  int bad   = 0;

  always #5 clock_c = ~clock_c;

  fft_pair_commutator #(.DATA_W(16), .DEPTH(4), .TW_W(1)) dut (
    .clock_c(clock_c), .reset_n(reset_n), .sync_clr(sync_clr), .in_en(in_en),
    .in_data(in_data), .out_en(out_en), .out_a(out_a), .out_b(out_b),
    .out_tw(out_tw), .out_first(out_first)
  );

  fft_pair_commutator #(.DATA_W(16), .DEPTH(512), .TW_W(1)) dut2 (
    .clock_c(clock_c), .reset_n(reset_n), .sync_clr(sync_clr2), .in_en(in_en2),
    .in_data(in_data2), .out_en(out_en2), .out_a(out_a2), .out_b(out_b2),
    .out_tw(out_tw2), .out_first(out_first2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic clr, input logic [15:0] d);
    @(negedge clock_c);
    in_en = en; sync_clr = clr; in_data = d;
    @(posedge clock_c);
    #1;
  endtask

  task automatic drive2(input logic [15:0] d);
    @(negedge clock_c);
    in_en2 = 1'b1; in_data2 = d;
    @(posedge clock_c);
    #1;
  endtask

  logic [15:0] blk [4];
  logic [15:0] blk2 [512];
  logic [15:0] d;
  int          pairs, since_first;

  initial begin
    // reset state
    #2;
    chk("rst_en", out_en, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_tw", out_tw, 0);
    chk("rst_first", out_first, 0);
    @(negedge clock_c); reset_n = 1'b1;

    // 1: continuous ramp
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      if (i < 4) chk("t1_fill_en", out_en, 0);
      else begin
        chk("t1_en", out_en, 1);
        chk("t1_a", out_a, 32'(i - 4));
        chk("t1_b", out_b, 32'(i));
        chk("t1_tw", out_tw, (i >= 6) ? 1 : 0);
        chk("t1_first", out_first, (i == 4) ? 1 : 0);
      end
    end

    // 2: gapped ramp, every accepted sample followed by an idle cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'(i));
      if (i < 4) chk("t2_fill_en", out_en, 0);
      else begin
        chk("t2_en", out_en, 1);
        chk("t2_a", out_a, 32'(i - 4));
        chk("t2_b", out_b, 32'(i));
        chk("t2_tw", out_tw, (i >= 6) ? 1 : 0);
        chk("t2_first", out_first, (i == 4) ? 1 : 0);
      end
      drive(1'b0, 1'b0, 16'hFFFF);
      chk("t2_gap_en", out_en, 0);
      if (i >= 4) begin
        chk("t2_gap_a_hold", out_a, 32'(i - 4));
        chk("t2_gap_b_hold", out_b, 32'(i));
      end
    end

    // 3: restart with a sample in the same cycle after 6 accepted samples
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0201 + 16'(i));
    drive(1'b1, 1'b1, 16'h00AA);
    chk("t3_clr_en", out_en, 0);
    chk("t3_clr_first", out_first, 0);
    blk[0] = 16'h00AA; blk[1] = 16'h0101; blk[2] = 16'h0102; blk[3] = 16'h0103;
    for (int j = 0; j < 7; j++) begin
      drive(1'b1, 1'b0, 16'h0101 + 16'(j));
      if (j < 3) chk("t3_fill_en", out_en, 0);
      else begin
        chk("t3_en", out_en, 1);
        chk("t3_a", out_a, blk[j - 3]);
        chk("t3_b", out_b, 32'h0104 + 32'(j - 3));
        chk("t3_tw", out_tw, (j >= 5) ? 1 : 0);
        chk("t3_first", out_first, (j == 3) ? 1 : 0);
      end
    end

    // 4: async reset pulse in the middle of the pair phase
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0301 + 16'(i));
    chk("t4_pre_en", out_en, 1);
    @(negedge clock_c);
    in_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_en", out_en, 0);
    chk("t4_rst_a", out_a, 0);
    chk("t4_rst_b", out_b, 0);
    chk("t4_rst_tw", out_tw, 0);
    chk("t4_rst_first", out_first, 0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0401 + 16'(i));
      if (i < 4) chk("t4_fill_en", out_en, 0);
      else begin
        chk("t4_en", out_en, 1);
        chk("t4_a", out_a, 32'h0401 + 32'(i - 4));
        chk("t4_b", out_b, 32'h0401 + 32'(i));
        chk("t4_first", out_first, (i == 4) ? 1 : 0);
      end
    end

    // 5: back-to-back random blocks against a scoreboard
    pairs = 0; since_first = 0;
    for (int n = 0; n < 32; n++) begin
      d = 16'($urandom);
      drive(1'b1, 1'b0, d);
      if ((n % 8) < 4) begin
        blk[n % 8] = d;
        chk("t5_fill_en", out_en, 0);
      end else begin
        chk("t5_en", out_en, 1);
        chk("t5_a", out_a, blk[(n % 8) - 4]);
        chk("t5_b", out_b, d);
        chk("t5_tw", out_tw, ((n % 8) >= 6) ? 1 : 0);
        chk("t5_first", out_first, ((n % 8) == 4) ? 1 : 0);
        if (out_first) begin
          if (pairs > 0) chk("t5_first_period", since_first, 4);
          since_first = 0;
        end
        since_first++;
        pairs++;
      end
    end
    chk("t5_pairs", pairs, 16);
    @(negedge clock_c); in_en = 1'b0;

    // 6: DEPTH=512 first stage, one 1024-sample block
    pairs = 0;
    for (int n = 0; n < 1024; n++) begin
      d = 16'($urandom);
      drive2(d);
      if (n < 512) begin
        blk2[n] = d;
        if (out_en2) chk("t6_fill_en", out_en2, 0);
      end else begin
        chk("t6_a", out_a2, blk2[n - 512]);
        chk("t6_b", out_b2, d);
        chk("t6_tw", out_tw2, (n - 512 >= 256) ? 1 : 0);
        if (out_en2) pairs++;
      end
    end
    chk("t6_pairs", pairs, 512);
    @(negedge clock_c); in_en2 = 1'b0;
    @(posedge clock_c); #1;
    chk("t6_idle_en", out_en2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
